// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared types, result encoding and sizing helper for serial_magnitude_comparator
package serial_cmp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Two-bit comparison result: equal until a differing bit decides it.
   localparam logic [1:0] RES_EQ = 2'b00;
   localparam logic [1:0] RES_GT = 2'b01;
   localparam logic [1:0] RES_LT = 2'b10;

   // The counter must hold N-1; clog2(N) bits do that, with a floor of one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_cmp_bit_cell.sv
// rtl/serial_cmp_bit_cell.sv - one MSB-first comparison step with a sticky decision
module serial_cmp_bit_cell
   import serial_cmp_pkg::*;
(
   input  logic       a_bit,
   input  logic       b_bit,
   input  logic       decided,
   input  logic [1:0] result,
   output logic       next_decided,
   output logic [1:0] next_result
);

   // The first differing bit fixes the result; later bits never override it.
   always_comb begin
      next_decided = decided;
      next_result  = result;
      if (!decided) begin
         if (a_bit && !b_bit) begin
            next_decided = 1'b1;
            next_result  = RES_GT;
         end else if (!a_bit && b_bit) begin
            next_decided = 1'b1;
            next_result  = RES_LT;
         end
      end
   end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - bit-serial unsigned comparator, optional SERIAL_CMP_EARLY_EXIT_EN
module serial_magnitude_comparator
   import serial_cmp_pkg::*;
#(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         greater,
   output logic         equal,
   output logic         lesser,
   output logic         busy
);

   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

   state_t        state;
   logic [N-1:0]  a_sh;
   logic [N-1:0]  b_sh;
   logic [CW-1:0] cnt;
   logic          decided;
   logic [1:0]    result;
   logic          next_decided;
   logic [1:0]    next_result;
   logic          finish;

   serial_cmp_bit_cell u_bit_cell (
      .a_bit        (a_sh[N-1]),
      .b_bit        (b_sh[N-1]),
      .decided      (decided),
      .result       (result),
      .next_decided (next_decided),
      .next_result  (next_result)
   );

`ifdef SERIAL_CMP_EARLY_EXIT_EN
   // Stop on the bit that first decides; equal operands still run all N bits.
   assign finish = (cnt == '0) || (next_decided && !decided);
`else
   // Fixed timing: always evaluate every bit.
   assign finish = (cnt == '0);
`endif

   // Handshake FSM, shift datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         cnt       <= '0;
         decided   <= 1'b0;
         result    <= RES_EQ;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         greater   <= 1'b0;
         equal     <= 1'b0;
         lesser    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  cnt      <= CNT_INIT;
                  decided  <= 1'b0;
                  result   <= RES_EQ;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               a_sh    <= a_sh << 1;
               b_sh    <= b_sh << 1;
               cnt     <= cnt - CW'(1);
               decided <= next_decided;
               result  <= next_result;
               if (finish) begin
                  out_valid <= 1'b1;
                  greater   <= (next_result == RES_GT);
                  lesser    <= (next_result == RES_LT);
                  equal     <= (next_result == RES_EQ);
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  greater   <= 1'b0;
                  equal     <= 1'b0;
                  lesser    <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - self-checking bench for serial_magnitude_comparator
module tb_serial_magnitude_comparator;

   localparam int N = 3;
   localparam int MAX_WAIT = 40;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic         greater;
   logic         equal;
   logic         lesser;
   logic         busy;

   int checks;
   int failures;

   serial_magnitude_comparator #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .greater   (greater),
      .equal     (equal),
      .lesser    (lesser),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] va;
      logic [N-1:0] vb;
      bit           g;
      bit           e;
      bit           l;
      int           lat;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: latency from the index of the most significant differing bit.
   function automatic int model_lat(input logic [N-1:0] ma, input logic [N-1:0] mb);
      int lat;
      lat = N;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      for (int i = 0; i < N; i++)
         if (ma[i] != mb[i]) lat = N - i;
`endif
      return lat;
   endfunction

   function automatic logic [2:0] model_flags(input logic [N-1:0] ma, input logic [N-1:0] mb);
      int ia;
      int ib;
      ia = int'(ma);
      ib = int'(mb);
      return {ia > ib, ia == ib, ia < ib};
   endfunction

   task automatic wait_ready(input string name);
      int g;
      g = 0;
      while (!in_ready && g < MAX_WAIT) begin
         @(posedge clk); #1;
         g++;
      end
      if (!in_ready) chk({name, "_ready_timeout"}, 0, 1);
   endtask

   // Accept one operand pair, measure latency, capture flags, then complete the output handshake.
   task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_, output logic [2:0] flags,
                         output int lat, output int shift_bad);
      wait_ready("run_op");
      a = ta;
      b = tb_;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = N'($urandom);
      b = N'($urandom);
      lat = 0;
      shift_bad = 0;
      while (!out_valid && lat < MAX_WAIT) begin
         if (greater || equal || lesser || in_ready || !busy) shift_bad++;
         @(posedge clk); #1;
         lat++;
      end
      flags = {greater, equal, lesser};
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (out_valid || !in_ready || busy || greater || equal || lesser) shift_bad++;
   endtask

   vec_t vecs[4];
   logic [2:0] mon_q[$];
   bit mon_en;

   // Result collector for the back-to-back run, sampled after each edge.
   always @(posedge clk) begin
      #1;
      if (mon_en && out_valid) mon_q.push_back({greater, equal, lesser});
   end

   initial begin
      logic [2:0] fl;
      int lat;
      int bad;
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      logic [N-1:0] seq_a[6];
      logic [N-1:0] seq_b[6];

      checks = 0;
      failures = 0;
      mon_en = 1'b0;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
      vecs[0] = '{3'b000, 3'b111, 1'b0, 1'b0, 1'b1, 1};
`else
      vecs[0] = '{3'b000, 3'b111, 1'b0, 1'b0, 1'b1, 3};
`endif
      vecs[1] = '{3'b101, 3'b101, 1'b0, 1'b1, 1'b0, 3};
      vecs[2] = '{3'b011, 3'b010, 1'b1, 1'b0, 1'b0, 3};
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      vecs[3] = '{3'b100, 3'b011, 1'b1, 1'b0, 1'b0, 1};
`else
      vecs[3] = '{3'b100, 3'b011, 1'b1, 1'b0, 1'b0, 3};
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_flags", {greater, equal, lesser}, 0);
      chk("reset_busy", busy, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed table
      for (int i = 0; i < 4; i++) begin
         run_op(vecs[i].va, vecs[i].vb, fl, lat, bad);
         chk($sformatf("vec%0d_flags", i), fl, {vecs[i].g, vecs[i].e, vecs[i].l});
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d_idle_outputs", i), bad, 0);
      end

      // Result held while out_ready is low and new operands are offered
      wait_ready("hold");
      a = 3'b001; b = 3'b000; in_valid = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (!out_valid && lat < MAX_WAIT) begin
         in_valid = ~in_valid;
         a = N'($urandom); b = N'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      chk("hold_latency", lat, model_lat(3'b001, 3'b000));
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         in_valid = ~in_valid;
         a = 3'b000; b = 3'b111;
         @(posedge clk); #1;
         if (!out_valid || in_ready || {greater, equal, lesser} != 3'b100) bad++;
      end
      chk("hold_stable", bad, 0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("hold_release_out_valid", out_valid, 0);
      chk("hold_release_in_ready", in_ready, 1);
      @(posedge clk); #1;
      chk("hold_no_reaccept", busy, 0);

      // Reset in the middle of an operation
      wait_ready("rst_mid");
      a = 3'b111; b = 3'b010; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_outputs", {out_valid, greater, equal, lesser, busy}, 0);
      chk("midrst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      run_op(3'b010, 3'b010, fl, lat, bad);
      chk("after_rst_flags", fl, 3'b010);
      chk("after_rst_latency", lat, N);

      // Back-to-back with out_ready tied high
      seq_a = '{3'b000, 3'b001, 3'b101, 3'b011, 3'b010, 3'b111};
      seq_b = '{3'b111, 3'b000, 3'b101, 3'b100, 3'b010, 3'b111};
      mon_q.delete();
      out_ready = 1'b1;
      mon_en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         a = seq_a[k]; b = seq_b[k]; in_valid = 1'b1;
         wait_ready("b2b");
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (2 * N + 6) @(posedge clk);
      #2;
      mon_en = 1'b0;
      out_ready = 1'b0;
      chk("b2b_count", mon_q.size(), 6);
      for (int k = 0; k < 6; k++) begin
         if (k < mon_q.size())
            chk($sformatf("b2b_flags%0d", k), mon_q[k], model_flags(seq_a[k], seq_b[k]));
      end

      // Randomized against the reference model
      for (int k = 0; k < 40; k++) begin
         ra = N'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : N'($urandom);
         run_op(ra, rb, fl, lat, bad);
         chk($sformatf("rand%0d_flags", k), fl, model_flags(ra, rb));
         chk($sformatf("rand%0d_latency", k), lat, model_lat(ra, rb));
         chk($sformatf("rand%0d_idle_outputs", k), bad, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Sequential counterpart to the team's parallel n_bit_comparator.
- Accepts two unsigned N-bit operands over a valid/ready handshake and compares them bit-serially, MSB first.
- Returns one-hot greater/equal/lesser flags over a second valid/ready handshake.
- Used where area matters more than latency, and as a cross-check reference against the parallel comparator in system benches.

Parameters:
- N, 3, operand width in bits (unsigned); legal range N >= 1.

Ports:
- clk  input  1  single clock, all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a/b are presented
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  N  operand A, sampled on the accept edge only
- b  input  N  operand B, sampled on the accept edge only
- out_valid  output  1  result flags are valid
- out_ready  input  1  downstream consumes the result
- greater  output  1  a > b, valid while out_valid is high
- equal  output  1  a == b, valid while out_valid is high
- lesser  output  1  a < b, valid while out_valid is high
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Interface decided: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE; out_valid, greater, equal, lesser, busy = 0; in_ready = 1.
  - Shift registers and bit counter are cleared.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready = 1.
  - On a clk edge with in_valid & in_ready (the accept edge E0), load a and b into shift registers, set counter = N-1, clear the sticky result, and go to SHIFT.
- SHIFT:
  - Each edge compares the current MSBs of both shift registers, then shifts both left by one and decrements the counter.
  - A sticky "decided" flag latches the first differing bit: a_bit=1 and b_bit=0 sets gt; the reverse sets lt.
  - Later bits never override a decided result.
  - When the counter reaches 0 (the bit-0 evaluation edge), go to DONE.
- Latency without early exit: bit N-1 is evaluated at edge E1 and bit 0 at edge EN. out_valid rises at EN, exactly N cycles after the accept edge, independent of the data.
- DONE:
  - out_valid = 1 and exactly one flag is high; equal = 1 iff no bit differed.
  - Flags stay stable until the handshake completes.
  - On an edge with out_ready = 1, go to IDLE and clear out_valid and all flags.
  - in_ready returns the following cycle; there is no same-cycle re-accept.
- Outside DONE all three flags are 0.
- in_valid is ignored in SHIFT and DONE. Operand changes after E0 have no effect.
- out_ready is ignored outside DONE.
- N = 1: a single SHIFT edge, latency 1.
- Reset mid-operation: the operation is abandoned, no out_valid is produced, and the block returns to IDLE.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined: SHIFT goes to DONE on the edge where the first differing bit (index i) is evaluated. Latency is N-i cycles.
- Defined, equal operands: latency stays N.
- Undefined: latency is always N, giving fixed timing.
- Flag values are identical in both builds.

Decomposition:
- Package serial_cmp_pkg holds:
  - the state typedef (IDLE/SHIFT/DONE);
  - the 2-bit result encoding constants RES_EQ, RES_GT, RES_LT;
  - a function that builds the counter width as clog2(N), minimum 1.
- One sub-module, serial_cmp_bit_cell:
  - combinational 1-bit step;
  - inputs: a_bit, b_bit, decided, current result;
  - outputs: next decided and next result.
- The top level holds the FSM, shift registers, counter and handshakes.

Test Plan:
- N=3, a=000, b=111 -> lesser=1, greater=0, equal=0. out_valid rises 3 cycles after accept (1 cycle with SERIAL_CMP_EARLY_EXIT_EN).
- a=101, b=101 -> equal=1 with latency 3 in both builds; greater=lesser=0 throughout.
- a=011, b=010 (differ only at bit 0) -> greater=1 with latency 3 in both builds.
- a=001, b=000 result, out_ready held low 5 cycles while in_valid toggles with new operands -> greater=1 stays stable, in_ready=0, and new operands are ignored. After out_ready=1: out_valid=0 next cycle and in_ready=1.
- Accept a=111, b=010, then assert rst one cycle later -> all outputs 0 immediately, in_ready=1. A following a=010, b=010 yields equal=1 normally.
- Back-to-back sequence (000/111, 001/000, 101/101, 011/100, 010/010, 111/111) with out_ready tied high -> flags match the parallel comparator for every pair, with no lost or duplicated results.
